keccak_obytes_unpacker: RTL and testbench

- Downstream consumer of the keccak sponge core. Its 64-bit squeeze words are fire-and-forget: valid only, no ready.
- Buffers those words in a FIFO and serialises them into a byte stream with a valid/ready handshake.
- Trims the stream to the requested output length, flags the final byte, and reports FIFO overflow.
- Sits between the sponge core's o_obytes/o_obytes_valid/o_obytes_done and the system byte sink.

---
 rtl/keccak_pkg.sv | 18 +
 rtl/keccak_obytes_unpacker_if.sv | 24 ++
 rtl/keccak_word_fifo.sv | 53 +++++
 rtl/keccak_obytes_unpacker.sv | 131 +++++++++++++
 tb/tb_keccak_obytes_unpacker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared keccak definitions: sponge word width, rate/digest constants and the
// unpacker state encoding.
package keccak_pkg;

  localparam int KECCAK_WORD_W   = 64;
  localparam int RATE_SHAKE128   = 168;
  localparam int RATE_SHA3_256   = 136;
  localparam int RATE_SHA3_512   = 72;
  localparam int DIGEST_SHA3_256 = 32;
  localparam int DIGEST_SHA3_512 = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_e;

endpackage

// File: rtl/keccak_obytes_unpacker_if.sv
// Squeeze-word input and byte-stream output bundle of the obytes unpacker.
// The slave modport is the unpacker; master is the core/sink environment.
interface keccak_obytes_unpacker_if;
  import keccak_pkg::*;

  logic [KECCAK_WORD_W-1:0] words;
  logic                     words_valid;
  logic                     core_done;
  logic [7:0]               byte_data;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     byte_last;

  modport master (
    output words, words_valid, core_done, byte_ready,
    input  byte_data, byte_valid, byte_last
  );

  modport slave (
    input  words, words_valid, core_done, byte_ready,
    output byte_data, byte_valid, byte_last
  );

endinterface

// File: rtl/keccak_word_fifo.sv
// Single-clock word FIFO with show-ahead head, flush, full/empty/count.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module keccak_word_fifo #(
  parameter int FIFO_DEPTH = 32,
  parameter int WIDTH      = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_flush,
  input  logic                        i_wr,
  input  logic [WIDTH-1:0]            i_din,
  input  logic                        i_rd,
  output logic [WIDTH-1:0]            o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wp_q, rp_q;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             rd_s, wr_s;

  assign o_empty = (wp_q == rp_q);
  assign o_full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign o_count = wp_q - rp_q;
  assign o_dout  = mem_q[rp_q[AW-1:0]];

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign rd_s = i_rd && !o_empty;
  assign wr_s = i_wr && (!o_full || rd_s);

  // Pointer update; flush empties the FIFO and overrides any access.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wp_q <= {(AW+1){1'b0}};
      rp_q <= {(AW+1){1'b0}};
    end else if (i_flush) begin
      wp_q <= {(AW+1){1'b0}};
      rp_q <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) wp_q <= wp_q + PTR_ONE;
      if (rd_s) rp_q <= rp_q + PTR_ONE;
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    if (wr_s && !i_flush) mem_q[wp_q[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/keccak_obytes_unpacker.sv
// Buffers sponge squeeze words and serialises them into a trimmed byte stream.
// Define KECCAK_UNPACK_LSB_FIRST_EN to emit each word LSB-first instead of MSB-first.
module keccak_obytes_unpacker
  import keccak_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_obytes_len,
  keccak_obytes_unpacker_if.slave    bus,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic                       o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};

  state_e                   state_q;
  logic [LEN_W-1:0]         rem_q;
  logic [KECCAK_WORD_W-1:0] sh_q;
  logic [2:0]               idx_q;
  logic                     ub_valid_q;
  logic                     ovf_q;
  logic                     done_q;

  logic                     run_s, xfer_s, final_s, pop_s, wr_s, drop_s, short_s, flush_s;
  logic [KECCAK_WORD_W-1:0] fifo_dout_s, sh_next_s;
  logic                     fifo_full_s, fifo_empty_s;
  logic [AW:0]              fifo_cnt_s;
  logic [7:0]               byte_cur_s;

  // i_start pre-empts any same-cycle write, transfer or pop.
  assign run_s   = (state_q == S_RUN) && !i_start;
  assign xfer_s  = ub_valid_q && bus.byte_ready;
  assign final_s = run_s && xfer_s && (rem_q == REM_ONE);
  assign pop_s   = run_s && !final_s && !fifo_empty_s &&
                   (!ub_valid_q || (xfer_s && (idx_q == 3'd7)));
  assign wr_s    = run_s && !final_s && bus.words_valid;
  assign drop_s  = wr_s && fifo_full_s && !pop_s;
  assign short_s = run_s && bus.core_done && (rem_q != REM_ZERO) &&
                   (fifo_cnt_s == {(AW+1){1'b0}}) && !ub_valid_q;
  assign flush_s = i_start || final_s;

`ifdef KECCAK_UNPACK_LSB_FIRST_EN
  assign byte_cur_s = sh_q[7:0];
  assign sh_next_s  = {8'h00, sh_q[KECCAK_WORD_W-1:8]};
`else
  assign byte_cur_s = sh_q[KECCAK_WORD_W-1:KECCAK_WORD_W-8];
  assign sh_next_s  = {sh_q[KECCAK_WORD_W-9:0], 8'h00};
`endif

  keccak_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (KECCAK_WORD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (flush_s),
    .i_wr    (wr_s),
    .i_din   (bus.words),
    .i_rd    (pop_s),
    .o_dout  (fifo_dout_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s),
    .o_count (fifo_cnt_s)
  );

  // Control FSM together with the unpack shift register, length counter and flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      rem_q      <= REM_ZERO;
      sh_q       <= {KECCAK_WORD_W{1'b0}};
      idx_q      <= 3'd0;
      ub_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else if (i_start) begin
      state_q    <= (i_obytes_len == REM_ZERO) ? S_END : S_RUN;
      done_q     <= (i_obytes_len == REM_ZERO);
      rem_q      <= i_obytes_len;
      sh_q       <= {KECCAK_WORD_W{1'b0}};
      idx_q      <= 3'd0;
      ub_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
        end
        S_RUN: begin
          if (drop_s) ovf_q <= 1'b1;
          if (xfer_s) rem_q <= rem_q - REM_ONE;
          if (final_s) begin
            // Leftover bytes of the current word and the FIFO are discarded.
            state_q    <= S_END;
            done_q     <= 1'b1;
            ub_valid_q <= 1'b0;
            idx_q      <= 3'd0;
          end else if (short_s) begin
            state_q <= S_END;
            done_q  <= 1'b1;
            ovf_q   <= 1'b1;
          end else if (pop_s) begin
            sh_q       <= fifo_dout_s;
            idx_q      <= 3'd0;
            ub_valid_q <= 1'b1;
          end else if (xfer_s) begin
            if (idx_q == 3'd7) ub_valid_q <= 1'b0;
            idx_q <= idx_q + 3'd1;
            sh_q  <= sh_next_s;
          end
        end
        S_END: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_data  = byte_cur_s;
  assign bus.byte_valid = ub_valid_q;
  assign bus.byte_last  = ub_valid_q && (rem_q == REM_ONE);
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_keccak_obytes_unpacker.sv
// Scoreboard bench for keccak_obytes_unpacker: expected bytes are queued as words
// are driven and popped on every handshake.
module tb_keccak_obytes_unpacker;
  import keccak_pkg::*;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             done, ovf, busy;

  keccak_obytes_unpacker_if bus();

  keccak_obytes_unpacker #(.FIFO_DEPTH(32), .LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_obytes_len (len),
    .bus          (bus),
    .o_done       (done),
    .o_overflow   (ovf),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails = 0;
  int         sb_pushed = 0;
  logic [7:0] exp_q[$];
  logic       s_valid, s_last, s_done, s_ovf, s_busy;
  logic [7:0] s_byte;

  function automatic logic [7:0] exp_byte(input logic [63:0] w, input int j);
`ifdef KECCAK_UNPACK_LSB_FIRST_EN
    return w[8*j +: 8];
`else
    return w[63-8*j -: 8];
`endif
  endfunction

  task automatic sb_push(input logic [63:0] w, input int l);
    for (int j = 0; j < 8; j++) begin
      if (sb_pushed < l) begin
        exp_q.push_back(exp_byte(w, j));
        sb_pushed++;
      end
    end
  endtask

  task automatic sb_clear();
    exp_q.delete();
    sb_pushed = 0;
  endtask

  // One clock: drive inputs after the falling edge, sample outputs 1 ns later.
  task automatic cyc(input logic wv, input logic [63:0] w, input logic rdy,
                     input logic st, input logic [LEN_W-1:0] l, input logic cd);
    @(negedge clk);
    bus.words_valid = wv;
    bus.words       = w;
    bus.byte_ready  = rdy;
    bus.core_done   = cd;
    start           = st;
    len             = l;
    #1;
    s_valid = bus.byte_valid;
    s_byte  = bus.byte_data;
    s_last  = bus.byte_last;
    s_done  = done;
    s_ovf   = ovf;
    s_busy  = busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.words_valid = 1'b0; bus.words = 64'd0; bus.byte_ready = 1'b0; bus.core_done = 1'b0;
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    n_checks++;
    if ({s_valid, s_byte, s_last, s_done, s_ovf, s_busy} !== 13'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got v=%b b=%h l=%b d=%b o=%b busy=%b want all 0",
               s_valid, s_byte, s_last, s_done, s_ovf, s_busy);
    end
    rstn = 1'b1;
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 10'd0, 1'b0);
    n_checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", s_busy, s_valid);
    end
  endtask

  task automatic test_sha3_256();
    int first_v, last_it, done_it, ndone, nbytes;
    logic [63:0] w;
    logic [7:0] e;
    first_v = -1; last_it = -1; done_it = -1; ndone = 0; nbytes = 0;
    sb_clear();
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd32, 1'b0);
    for (int it = 0; it < 60; it++) begin
      w = 64'h0001020304050607 + 64'(it) * 64'h0808080808080808;
      if (it < 4) sb_push(w, 32);
      cyc(it < 4, w, 1'b1, 1'b0, 10'd32, 1'b0);
      if (s_done) begin ndone++; done_it = it; end
      if (s_valid) begin
        if (first_v < 0) first_v = it;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL sha256_extra: got byte %h want no byte", s_byte);
        end else begin
          e = exp_q.pop_front();
          if (s_byte !== e || s_last !== (nbytes == 31)) begin
            n_fails++;
            $display("FAIL sha256_byte%0d: got %h last=%b want %h last=%b",
                     nbytes, s_byte, s_last, e, (nbytes == 31));
          end
        end
        if (s_last) last_it = it;
        nbytes++;
      end
    end
    n_checks++;
    if (nbytes != 32 || first_v != 2 || last_it != 33) begin
      n_fails++;
      $display("FAIL sha256_timing: got n=%0d first=%0d last=%0d want 32 2 33", nbytes, first_v, last_it);
    end
    n_checks++;
    if (ndone != 1 || done_it != 34 || s_ovf !== 1'b0 || s_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL sha256_done: got ndone=%0d at %0d ovf=%b busy=%b want 1 at 34 0 0",
               ndone, done_it, s_ovf, s_busy);
    end
  endtask

  task automatic test_trim();
    int ndone, nbytes;
    logic [63:0] w;
    logic [7:0] e;
    ndone = 0; nbytes = 0;
    sb_clear();
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd13, 1'b0);
    for (int it = 0; it < 30; it++) begin
      w = {$urandom, $urandom};
      if (it < 3) sb_push(w, 13);
      cyc(it < 3, w, 1'b1, 1'b0, 10'd13, 1'b0);
      if (s_done) begin
        ndone++;
        n_checks++;
        if (dut.u_fifo.o_empty !== 1'b1) begin
          n_fails++;
          $display("FAIL trim_fifo_flush: got empty=%b want 1", dut.u_fifo.o_empty);
        end
      end
      if (s_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL trim_extra: got byte %h want no byte", s_byte);
        end else begin
          e = exp_q.pop_front();
          if (s_byte !== e || s_last !== (nbytes == 12)) begin
            n_fails++;
            $display("FAIL trim_byte%0d: got %h last=%b want %h last=%b",
                     nbytes, s_byte, s_last, e, (nbytes == 12));
          end
        end
        nbytes++;
      end
    end
    n_checks++;
    if (nbytes != 13 || ndone != 1) begin
      n_fails++;
      $display("FAIL trim_count: got n=%0d ndone=%0d want 13 1", nbytes, ndone);
    end
  endtask

  task automatic test_backpressure();
    int ndone, nbytes;
    logic [63:0] w;
    logic [7:0] e, prev_byte;
    logic rdy, prev_stall;
    ndone = 0; nbytes = 0; prev_stall = 1'b0; prev_byte = 8'd0;
    sb_clear();
    cyc(1'b0, 64'd0, 1'b0, 1'b1, 10'd168, 1'b0);
    for (int it = 0; it < 800; it++) begin
      w = {$urandom, $urandom};
      rdy = ((it % 4) == 3);
      if (it < 21) sb_push(w, 168);
      cyc(it < 21, w, rdy, 1'b0, 10'd168, 1'b0);
      if (s_done) ndone++;
      if (prev_stall) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_byte !== prev_byte) begin
          n_fails++;
          $display("FAIL bp_stable: got v=%b b=%h want 1 %h", s_valid, s_byte, prev_byte);
        end
      end
      prev_stall = s_valid && !rdy;
      prev_byte  = s_byte;
      if (s_valid && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL bp_extra: got byte %h want no byte", s_byte);
        end else begin
          e = exp_q.pop_front();
          if (s_byte !== e || s_last !== (nbytes == 167)) begin
            n_fails++;
            $display("FAIL bp_byte%0d: got %h last=%b want %h last=%b",
                     nbytes, s_byte, s_last, e, (nbytes == 167));
          end
        end
        nbytes++;
      end
    end
    n_checks++;
    if (nbytes != 168 || ndone != 1 || s_ovf !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_summary: got n=%0d ndone=%0d ovf=%b want 168 1 0", nbytes, ndone, s_ovf);
    end
  endtask

  task automatic test_overflow();
    int ovf_it, ndone, nbytes;
    logic [63:0] w;
    logic [7:0] e;
    ovf_it = -1; ndone = 0; nbytes = 0;
    sb_clear();
    cyc(1'b0, 64'd0, 1'b0, 1'b1, 10'd800, 1'b0);
    for (int it = 0; it < 45; it++) begin
      cyc(it < 40, {$urandom, $urandom}, 1'b0, 1'b0, 10'd800, 1'b0);
      if (s_ovf && ovf_it < 0) ovf_it = it;
    end
    n_checks++;
    if (ovf_it != 34) begin
      n_fails++;
      $display("FAIL ovf_word: got first overflow at %0d want 34", ovf_it);
    end
    // Restart clears the flag and the stream carries only the new word.
    cyc(1'b0, 64'd0, 1'b0, 1'b1, 10'd8, 1'b0);
    w = 64'hDEADBEEFCAFEF00D;
    for (int it = 0; it < 16; it++) begin
      if (it == 0) sb_push(w, 8);
      cyc(it == 0, w, 1'b1, 1'b0, 10'd8, 1'b0);
      if (it == 0) begin
        n_checks++;
        if (s_ovf !== 1'b0) begin
          n_fails++;
          $display("FAIL ovf_clear: got %b want 0", s_ovf);
        end
      end
      if (s_done) ndone++;
      if (s_valid) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (s_byte !== e || s_last !== (nbytes == 7)) begin
          n_fails++;
          $display("FAIL ovf_restart_byte%0d: got %h last=%b want %h last=%b",
                   nbytes, s_byte, s_last, e, (nbytes == 7));
        end
        nbytes++;
      end
    end
    n_checks++;
    if (nbytes != 8 || ndone != 1) begin
      n_fails++;
      $display("FAIL ovf_restart_count: got n=%0d ndone=%0d want 8 1", nbytes, ndone);
    end
  endtask

  task automatic test_len_zero();
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd0, 1'b0);
    cyc(1'b1, 64'h1122334455667788, 1'b1, 1'b0, 10'd0, 1'b0);
    n_checks++;
    if (s_done !== 1'b1 || s_valid !== 1'b0 || s_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL len0_done: got d=%b v=%b busy=%b want 1 0 1", s_done, s_valid, s_busy);
    end
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 10'd0, 1'b0);
    n_checks++;
    if (s_done !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
      n_fails++;
      $display("FAIL len0_idle: got d=%b v=%b busy=%b want 0 0 0", s_done, s_valid, s_busy);
    end
  endtask

  task automatic test_abort();
    int first_v, ndone, nbytes;
    logic [63:0] w;
    logic [7:0] e;
    nbytes = 0;
    sb_clear();
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd32, 1'b0);
    for (int it = 0; it < 20 && nbytes < 5; it++) begin
      w = 64'hA0A1A2A3A4A5A6A7 + 64'(it);
      cyc(it < 4, w, 1'b1, 1'b0, 10'd32, 1'b0);
      if (s_valid) nbytes++;
    end
    // Abort with a simultaneous junk word and ready transfer; both must be ignored.
    cyc(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 10'd8, 1'b0);
    sb_clear();
    first_v = -1; ndone = 0; nbytes = 0;
    w = 64'h0123456789ABCDEF;
    for (int it = 0; it < 16; it++) begin
      if (it == 0) sb_push(w, 8);
      cyc(it == 0, w, 1'b1, 1'b0, 10'd8, 1'b0);
      if (s_done) ndone++;
      if (s_valid) begin
        if (first_v < 0) first_v = it;
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (s_byte !== e || s_last !== (nbytes == 7)) begin
          n_fails++;
          $display("FAIL abort_byte%0d: got %h last=%b want %h last=%b",
                   nbytes, s_byte, s_last, e, (nbytes == 7));
        end
        nbytes++;
      end
    end
    n_checks++;
    if (nbytes != 8 || ndone != 1 || first_v != 2) begin
      n_fails++;
      $display("FAIL abort_clean: got n=%0d ndone=%0d first=%0d want 8 1 2", nbytes, ndone, first_v);
    end
  endtask

  task automatic test_short_msg();
    int done_it, nbytes;
    logic [63:0] w;
    done_it = -1; nbytes = 0;
    w = 64'h5A5B5C5D5E5F6061;
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd32, 1'b0);
    for (int it = 0; it < 15; it++) begin
      cyc(it == 0, w, 1'b1, 1'b0, 10'd32, it == 10);
      if (s_valid) nbytes++;
      if (s_done) done_it = it;
    end
    n_checks++;
    if (nbytes != 8 || done_it != 11 || s_ovf !== 1'b1) begin
      n_fails++;
      $display("FAIL short_msg: got n=%0d done_at=%0d ovf=%b want 8 11 1", nbytes, done_it, s_ovf);
    end
  endtask

  task automatic test_async_reset();
    int nbytes;
    nbytes = 0;
    cyc(1'b0, 64'd0, 1'b1, 1'b1, 10'd32, 1'b0);
    for (int it = 0; it < 20 && nbytes < 3; it++) begin
      cyc(it < 3, {$urandom, $urandom}, 1'b1, 1'b0, 10'd32, 1'b0);
      if (s_valid) nbytes++;
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.byte_valid, bus.byte_data, bus.byte_last, done, ovf, busy} !== 13'd0) begin
      n_fails++;
      $display("FAIL async_reset: got v=%b b=%h l=%b d=%b o=%b busy=%b want all 0",
               bus.byte_valid, bus.byte_data, bus.byte_last, done, ovf, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 10'd0, 1'b0);
    n_checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset_idle: got busy=%b valid=%b want 0 0", s_busy, s_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sha3_256();
    test_trim();
    test_backpressure();
    test_overflow();
    test_len_zero();
    test_abort();
    test_short_msg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
